alu_seq_ctrl: RTL and testbench

//  Sequencer for the 4-bit combinational ALU (simple_alu). Accepts one instruction per

---
 rtl/alu_seq_pkg.sv | 22 ++
 rtl/simple_alu.sv | 35 +++
 rtl/alu_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: widths, opcodes and FSM states.
package alu_seq_pkg;

    localparam int unsigned DW   = 4;
    localparam int unsigned NREG = 4;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_SLLI = 3'd6;
    localparam logic [2:0] OP_SRLI = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

endpackage

// File: rtl/simple_alu.sv
// 4-bit combinational ALU; overflow is reported only for ADD/SUB.
module simple_alu
    import alu_seq_pkg::*;
(
    input  logic [2:0]    op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] y_o,
    output logic          ovf_o
);

    // Result and two's-complement overflow for the selected operation.
    always_comb begin
        y_o   = '0;
        ovf_o = 1'b0;
        case (op_i)
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_ADD: begin
                y_o   = a_i + b_i;
                ovf_o = (a_i[DW-1] == b_i[DW-1]) && (y_o[DW-1] != a_i[DW-1]);
            end
            OP_SUB: begin
                y_o   = a_i - b_i;
                ovf_o = (a_i[DW-1] != b_i[DW-1]) && (y_o[DW-1] != a_i[DW-1]);
            end
            // Shift amounts of DW or more flush the operand completely.
            OP_SLLI: y_o = (|b_i[DW-1:2]) ? '0 : (a_i << b_i);
            OP_SRLI: y_o = (|b_i[DW-1:2]) ? '0 : (a_i >> b_i);
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Three-cycle instruction sequencer around simple_alu with a 4x4 register
// file, done/result reporting and a sticky overflow flag.
module alu_seq_ctrl
    import alu_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [1:0]    in_rd,
    input  logic [1:0]    in_rs1,
    input  logic [1:0]    in_rs2,
    input  logic [DW-1:0] in_imm,
    input  logic          in_use_imm,
    input  logic          clr_ovf,
    output logic          done,
    output logic [DW-1:0] done_result,
    output logic          done_ovf,
    output logic          sticky_ovf,
    input  logic [1:0]    dbg_rsel,
    output logic [DW-1:0] dbg_rdata
);

    state_e        state_q, state_d;
    logic          accept;
    logic          wb;

    logic [2:0]    op_q;
    logic [1:0]    rd_q;
    logic [DW-1:0] a_q, b_q;
    logic [DW-1:0] res_q;
    logic          ovf_q;
    logic [DW-1:0] alu_y;
    logic          alu_ovf;

    logic [DW-1:0] rf_q [NREG];

    logic          done_q;
    logic [DW-1:0] done_result_q;
    logic          done_ovf_q;
    logic          sticky_q;

    simple_alu u_alu (
        .op_i  (op_q),
        .a_i   (a_q),
        .b_i   (b_q),
        .y_o   (alu_y),
        .ovf_o (alu_ovf)
    );

    // FSM state register; reset aborts any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state, handshake and write-back strobe.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        wb       = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) state_d = S_EXEC;
            end
            S_EXEC: state_d = S_WB;
            S_WB: begin
                wb      = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Latch instruction and operands at accept, capture ALU output in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_NOP;
            rd_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= in_op;
                rd_q <= in_rd;
                a_q  <= rf_q[in_rs1];
                b_q  <= in_use_imm ? in_imm : rf_q[in_rs2];
            end
            if (state_q == S_EXEC) begin
                res_q <= alu_y;
                ovf_q <= alu_ovf;
            end
        end
    end

    // Register file write-back; NOP retires without writing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wb && (op_q != OP_NOP)) begin
            rf_q[rd_q] <= res_q;
        end
    end

    // Completion report: one-cycle done, result/ovf held until next retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q        <= 1'b0;
            done_result_q <= '0;
            done_ovf_q    <= 1'b0;
        end else begin
            done_q <= wb;
            if (wb) begin
                done_result_q <= res_q;
                done_ovf_q    <= ovf_q;
            end
        end
    end

    // Sticky overflow; a retiring overflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              sticky_q <= 1'b0;
        else if (wb && ovf_q)    sticky_q <= 1'b1;
        else if (clr_ovf)        sticky_q <= 1'b0;
    end

    assign done        = done_q;
    assign done_result = done_result_q;
    assign done_ovf    = done_ovf_q;
    assign sticky_ovf  = sticky_q;
    assign dbg_rdata   = rf_q[dbg_rsel];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed instruction sequence, a cycle-level
// behavioural model compared every cycle, plus literal expectations.
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [1:0] in_rd, in_rs1, in_rs2;
    logic [3:0] in_imm;
    logic       in_use_imm;
    logic       clr_ovf;
    logic       done;
    logic [3:0] done_result;
    logic       done_ovf;
    logic       sticky_ovf;
    logic [1:0] dbg_rsel;
    logic [3:0] dbg_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .in_use_imm  (in_use_imm),
        .clr_ovf     (clr_ovf),
        .done        (done),
        .done_result (done_result),
        .done_ovf    (done_ovf),
        .sticky_ovf  (sticky_ovf),
        .dbg_rsel    (dbg_rsel),
        .dbg_rdata   (dbg_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference ALU from integer arithmetic; returns {ovf, result[3:0]}.
    function automatic logic [4:0] alu_model(input logic [2:0] op, input int a, input int b);
        int sa, sb, s, r;
        bit o;
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        r = 0;
        o = 1'b0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_ADD:  begin r = (a + b) % 16;      s = sa + sb; o = (s > 7) || (s < -8); end
            OP_SUB:  begin r = (a - b + 16) % 16; s = sa - sb; o = (s > 7) || (s < -8); end
            OP_SLLI: r = (b >= 4) ? 0 : (a * (1 << b)) % 16;
            OP_SRLI: r = (b >= 4) ? 0 : a / (1 << b);
            default: r = 0;
        endcase
        return {o, r[3:0]};
    endfunction

    // Model: an accepted instruction is computed immediately and retires
    // two edges after the accepting edge; the controller is busy meanwhile.
    logic [3:0] m_reg [4];
    bit         m_busy;
    int         m_cnt;
    logic [2:0] m_op;
    logic [1:0] m_rd;
    logic [3:0] m_pres;
    logic       m_povf;
    logic       m_done;
    logic [3:0] m_res;
    logic       m_ovf;
    logic       m_sticky;
    bit         m_retire;
    logic [4:0] m_tmp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_reg[i] = 4'h0;
            m_busy = 0; m_cnt = 0; m_done = 1'b0;
            m_res = 4'h0; m_ovf = 1'b0; m_sticky = 1'b0;
        end else begin
            m_done   = 1'b0;
            m_retire = 0;
            if (!m_busy) begin
                if (in_valid) begin
                    m_op  = in_op;
                    m_rd  = in_rd;
                    m_tmp = alu_model(in_op, int'(m_reg[in_rs1]),
                                      in_use_imm ? int'(in_imm) : int'(m_reg[in_rs2]));
                    m_pres = m_tmp[3:0];
                    m_povf = m_tmp[4];
                    m_busy = 1;
                    m_cnt  = 2;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 0;
                    if (m_op != OP_NOP) m_reg[m_rd] = m_pres;
                    m_done   = 1'b1;
                    m_res    = m_pres;
                    m_ovf    = m_povf;
                    m_retire = 1;
                end
            end
            if (m_retire && m_povf) m_sticky = 1'b1;
            else if (clr_ovf)       m_sticky = 1'b0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(posedge clk) begin
        #3;
        if (rst_n) begin
            chk("cyc_in_ready",    32'(in_ready),    32'(!m_busy));
            chk("cyc_done",        32'(done),        32'(m_done));
            chk("cyc_done_result", 32'(done_result), 32'(m_res));
            chk("cyc_done_ovf",    32'(done_ovf),    32'(m_ovf));
            chk("cyc_sticky_ovf",  32'(sticky_ovf),  32'(m_sticky));
            chk("cyc_dbg_rdata",   32'(dbg_rdata),   32'(m_reg[dbg_rsel]));
        end
    end

    task automatic tick();
        @(negedge clk);
        dbg_rsel = dbg_rsel + 2'd1;
    endtask

    task automatic reg_chk(input logic [1:0] idx, input logic [3:0] exp);
        dbg_rsel = idx;
        #1;
        chk($sformatf("R%0d", idx), 32'(dbg_rdata), 32'(exp));
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [3:0] imm, input logic use_imm);
        bit ok = 0;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_imm = imm; in_use_imm = use_imm; in_valid = 1'b1;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (in_ready) ok = 1;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input string name, input logic [3:0] exp_res, input logic exp_ovf);
        int n = 0;
        bit got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            n++;
            if (done) got = 1;
        end
        if (!got) begin
            chk({name, "_timeout"}, 32'(got), 32'd1);
        end else begin
            chk({name, "_latency"}, 32'(n), 32'd2);
            chk({name, "_result"}, 32'(done_result), 32'(exp_res));
            chk({name, "_ovf"}, 32'(done_ovf), 32'(exp_ovf));
        end
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [1:0] rd,
                       input logic [1:0] rs1, input logic [1:0] rs2, input logic [3:0] imm,
                       input logic use_imm, input logic [3:0] exp_res, input logic exp_ovf);
        issue(op, rd, rs1, rs2, imm, use_imm);
        wait_done(name, exp_res, exp_ovf);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        int acc, dn;
        rst_n = 1'b0; in_valid = 1'b0; in_op = OP_NOP; in_rd = 2'd0; in_rs1 = 2'd0;
        in_rs2 = 2'd0; in_imm = 4'h0; in_use_imm = 1'b0; clr_ovf = 1'b0; dbg_rsel = 2'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) reg_chk(2'(i), 4'h0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sticky", 32'(sticky_ovf), 32'd0);

        run("add_r1",   OP_ADD, 2'd1, 2'd0, 2'd0, 4'd7, 1'b1, 4'h7, 1'b0);
        run("add_r2",   OP_ADD, 2'd2, 2'd1, 2'd0, 4'd1, 1'b1, 4'h8, 1'b1);
        chk("sticky_after_add", 32'(sticky_ovf), 32'd1);
        reg_chk(2'd2, 4'h8);

        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("sticky_cleared", 32'(sticky_ovf), 32'd0);

        run("sub_ovf",  OP_SUB,  2'd3, 2'd2, 2'd0, 4'd1, 1'b1, 4'h7, 1'b1);
        run("sub_wrap", OP_SUB,  2'd3, 2'd0, 2'd0, 4'd1, 1'b1, 4'hF, 1'b0);
        run("set_r1",   OP_ADD,  2'd1, 2'd0, 2'd0, 4'd3, 1'b1, 4'h3, 1'b0);
        run("slli2",    OP_SLLI, 2'd3, 2'd1, 2'd0, 4'd2, 1'b1, 4'hC, 1'b0);
        run("srli3",    OP_SRLI, 2'd2, 2'd3, 2'd0, 4'd3, 1'b1, 4'h1, 1'b0);
        run("slli5",    OP_SLLI, 2'd0, 2'd1, 2'd0, 4'd5, 1'b1, 4'h0, 1'b0);
        run("xor_rr",   OP_XOR,  2'd2, 2'd1, 2'd3, 4'd0, 1'b0, 4'hF, 1'b0);
        run("and_rr",   OP_AND,  2'd2, 2'd1, 2'd3, 4'd0, 1'b0, 4'h0, 1'b0);
        run("or_rr",    OP_OR,   2'd2, 2'd1, 2'd3, 4'd9, 1'b0, 4'hF, 1'b0);
        run("add_self", OP_ADD,  2'd1, 2'd1, 2'd1, 4'd0, 1'b0, 4'h6, 1'b0);
        reg_chk(2'd1, 4'h6);
        reg_chk(2'd3, 4'hC);

        // Continuous valid with NOPs: accepts every third cycle, no writes.
        acc = 0; dn = 0;
        in_op = OP_NOP; in_rd = 2'd3; in_rs1 = 2'd1; in_rs2 = 2'd2;
        in_imm = 4'h5; in_use_imm = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (in_ready) acc++;
            tick();
            if (done) dn++;
        end
        in_valid = 1'b0;
        chk("stream_accepts", 32'(acc), 32'd4);
        chk("stream_dones", 32'(dn), 32'd4);
        chk("nop_result", 32'(done_result), 32'd0);
        reg_chk(2'd3, 4'hC);
        reg_chk(2'd2, 4'hF);

        // Reset during EXEC: no retirement follows.
        issue(OP_ADD, 2'd2, 2'd1, 2'd0, 4'd5, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) dn++;
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        reg_chk(2'd2, 4'h0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);

        // Clear held across an overflowing retirement: set wins.
        run("add_r1_b", OP_ADD, 2'd1, 2'd0, 2'd0, 4'd7, 1'b1, 4'h7, 1'b0);
        clr_ovf = 1'b1;
        run("add_ovf_clr", OP_ADD, 2'd2, 2'd1, 2'd0, 4'd1, 1'b1, 4'h8, 1'b1);
        clr_ovf = 1'b0;
        chk("sticky_set_wins", 32'(sticky_ovf), 32'd1);
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("sticky_final_clear", 32'(sticky_ovf), 32'd0);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
